aer_feature_pool: RTL

Upstream feature-extraction stage for the SVM classifier. Counts output-layer AER spike events per feature map over one sample frame, then serialises the saturated counts as the 10-element feature vector in the 4-cycle-per-element burst format the SVM classifier consumes. It sits between the last SCNN layer's AER output and the SVM input (`feature_vector_input` / `feature_vector_input_f`).

---
 rtl/aer_feature_pool_pkg.sv | 22 ++
 rtl/aer_feature_counter_bank.sv | 41 ++++
 rtl/aer_feature_pool.sv | 116 +++++++++++
 3 files changed

// File: rtl/aer_feature_pool_pkg.sv
// Shared widths, burst geometry and state encodings for the AER feature pooling stage.
package aer_feature_pool_pkg;

  localparam int unsigned N_FEAT    = 10;
  localparam int unsigned FEAT_W    = 7;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned SLOT      = 4;
  localparam int unsigned GAP_LEN   = 2;
  localparam int unsigned DATA_LEN  = N_FEAT * SLOT;
  localparam int unsigned BURST_LEN = DATA_LEN + 2;
  localparam int unsigned BIDX_W    = $clog2(BURST_LEN);
  localparam int unsigned GAP_W     = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [FEAT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

endpackage

// File: rtl/aer_feature_counter_bank.sv
// Bank of saturating per-feature-map spike counters with synchronous clear and indexed read.
module aer_feature_counter_bank
  import aer_feature_pool_pkg::*;
(
  input  logic              work_clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [FEAT_W-1:0] rd_data_c
);

  logic [FEAT_W-1:0] cnt_q [N_FEAT];

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_FEAT); i++) cnt_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(N_FEAT); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_FEAT); i++) begin
        if (inc_en && inc_addr == ADDR_W'(i) && cnt_q[i] != CNT_MAX)
          cnt_q[i] <= cnt_q[i] + FEAT_W'(1);
      end
    end
  end

  // Read returns the post-update value so an event landing with frame_end reaches element 0.
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < int'(N_FEAT); i++) begin
      if (rd_idx == ADDR_W'(i)) begin
        rd_data_c = cnt_q[i];
        if (inc_en && !clr && inc_addr == ADDR_W'(i) && cnt_q[i] != CNT_MAX)
          rd_data_c = cnt_q[i] + FEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/aer_feature_pool.sv
// Counts AER spikes per feature map over a frame, then streams the counts as a
// flagged 4-cycle-per-element burst for the SVM classifier.
module aer_feature_pool
  import aer_feature_pool_pkg::*;
(
  input  logic              work_clk,
  input  logic              rst_n,
  input  logic              aer_valid_i,
  input  logic [ADDR_W-1:0] aer_addr_i,
  output logic              aer_ready_o,
  input  logic              frame_end_i,
  output logic [FEAT_W-1:0] feature_vector_o,
  output logic              feature_vector_o_f,
  output logic              addr_err_o,
  output logic              frame_miss_o
);

  state_e            state_q, state_d;
  logic [BIDX_W-1:0] b_q, b_d;
  logic [GAP_W-1:0]  g_q, g_d;

  logic              accept_c;
  logic              addr_ok_c;
  logic              inc_en_c;
  logic              clr_c;
  logic [ADDR_W-1:0] rd_idx_c;
  logic [FEAT_W-1:0] rd_data_c;

  logic              ready_d;
  logic              flag_d;
  logic [FEAT_W-1:0] vec_d;
  logic              err_d;
  logic              miss_d;

  assign accept_c  = aer_valid_i && (state_q == ST_COUNT);
  assign addr_ok_c = aer_addr_i < ADDR_W'(N_FEAT);
  assign inc_en_c  = accept_c && addr_ok_c;
  assign clr_c     = (state_q == ST_GAP) && (g_q == GAP_W'(GAP_LEN - 1));
  assign rd_idx_c  = ADDR_W'(b_d / BIDX_W'(SLOT));

  aer_feature_counter_bank u_bank (
    .work_clk  (work_clk),
    .rst_n     (rst_n),
    .clr       (clr_c),
    .inc_en    (inc_en_c),
    .inc_addr  (aer_addr_i),
    .rd_idx    (rd_idx_c),
    .rd_data_c (rd_data_c)
  );

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COUNT;
      b_q     <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      g_q     <= g_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    g_d     = g_q;
    case (state_q)
      ST_COUNT: begin
        if (frame_end_i) begin
          state_d = ST_STREAM;
          b_d     = '0;
        end
      end
      ST_STREAM: begin
        if (b_q == BIDX_W'(BURST_LEN - 1)) begin
          state_d = ST_GAP;
          g_d     = '0;
        end else begin
          b_d = b_q + BIDX_W'(1);
        end
      end
      ST_GAP: begin
        if (g_q == GAP_W'(GAP_LEN - 1)) state_d = ST_COUNT;
        else                            g_d     = g_q + GAP_W'(1);
      end
      default: state_d = ST_COUNT;
    endcase
  end

  // Output values are computed for the upcoming state so every port is a flop.
  always_comb begin
    ready_d = (state_d == ST_COUNT);
    flag_d  = (state_d == ST_STREAM);
    vec_d   = '0;
    if (state_d == ST_STREAM && b_d < BIDX_W'(DATA_LEN)) vec_d = rd_data_c;
    err_d   = addr_err_o   || (accept_c && !addr_ok_c);
    miss_d  = frame_miss_o || (frame_end_i && state_q != ST_COUNT);
  end

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      aer_ready_o        <= 1'b1;
      feature_vector_o   <= '0;
      feature_vector_o_f <= 1'b0;
      addr_err_o         <= 1'b0;
      frame_miss_o       <= 1'b0;
    end else begin
      aer_ready_o        <= ready_d;
      feature_vector_o   <= vec_d;
      feature_vector_o_f <= flag_d;
      addr_err_o         <= err_d;
      frame_miss_o       <= miss_d;
    end
  end

endmodule
